nf_mailbox: RTL and testbench
=============================

// Module: nf_mailbox
// PURPOSE
//  Parametrised bidirectional mailbox between two bus masters (side 1, side 2) sharing one clock.
//  Each direction is a depth-entry FIFO: 1->2 written by side 1 and read by side 2; 2->1 the mirror.
//  Successor of the single-register exchange: adds buffering, flow control, fill levels and overflow flags.
//  Sits in periphery, between the core and a second agent (DMA, debug unit, second core).
// PARAMETERS
//  width     8   data word width, >= 1
//  depth     4   entries per direction; power of 2, >= 2
//  irq_level 1   fill level that raises irq_x (used only with NF_MAILBOX_IRQ_EN); 1..depth
// PORTS  (x = 1 or 2; y = the other side; lw = $clog2(depth)+1)
//  clk         in   1      system clock, all logic on posedge
//  resetn      in   1      asynchronous active-low reset
//  we_x        in   1      side x pushes data_x_in into FIFO x->y
//  data_x_in   in   width  write data from side x
//  re_x        in   1      side x pops head of FIFO y->x
//  data_x_out  out  width  head of FIFO y->x (first-word fall-through)
//  valid_x     out  1      FIFO y->x not empty; data_x_out meaningful
//  wait_x      out  1      FIFO x->y full; writes from side x are dropped
//  level_x     out  lw     entries currently in FIFO y->x (0..depth)
//  ovf_x       out  1      sticky: side x wrote while wait_x was high
//  ovf_clr_x   in   1      clears ovf_x
//  irq_x       out  1      only with NF_MAILBOX_IRQ_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, immediate): read/write pointers and counts = 0, valid_x = 0, wait_x = 0,
//    level_x = 0, ovf_x = 0, irq_x = 0, storage = 0, so data_x_out = 0.
//  - Per FIFO: depth x width register array, wr_ptr/rd_ptr of $clog2(depth) bits
//    wrapping depth-1 -> 0, separate count register 0..depth. full = (count == depth), empty = (count == 0).
//  - Write: on the posedge with we_x = 1 and full = 0, store at wr_ptr, wr_ptr++, count++.
//  - Read: on the posedge with re_y = 1 and empty = 0, rd_ptr++, count--. data_y_out = mem[rd_ptr], combinational from registers.
//  - Latency: word written at edge N is visible on data_y_out/valid_y after edge N (1 cycle).
//  - Accept/reject decisions use pre-edge flags only:
//    - write while full: word dropped, ovf_x set, pointers unchanged, even if re_y pops in the same cycle;
//    - read while empty: ignored, no error, even if a write lands in the same cycle;
//    - read+write, neither full nor empty: both happen, count unchanged.
//  - ovf_x: set when we_x & wait_x. Cleared by ovf_clr_x. Set wins over clear in the same cycle.
//  - level_x, valid_x, wait_x derive directly from registered counts; no extra latency.
//  - Directions fully independent; simultaneous activity on both sides never stalls either.
//  - Reset asserted mid-transfer discards all buffered words; no partial state survives.
// CONFIGURATION
//  NF_MAILBOX_IRQ_EN defined:
//    - ports irq_1, irq_2 exist;
//    - irq_x is registered: set on the edge after level_x >= irq_level, cleared on the edge after level_x < irq_level.
//  NF_MAILBOX_IRQ_EN undefined:
//    - irq ports and their logic absent; irq_level ignored;
//    - all other behaviour identical.
// TESTING  (width=8, depth=4 unless noted)
//  1 Reset, then we_1=1 with data 0xA5 for 1 cycle -> next cycle valid_2=1, data_2_out=0xA5, level_2=1.
//    re_2=1 for 1 cycle -> valid_2=0.
//  2 Write 0x01..0x04 from side 1 -> wait_1=1, level_2=4.
//    Write 0x05 -> dropped, ovf_1=1. Read 4 words -> 0x01..0x04 in order.
//    ovf_clr_1 -> ovf_1=0.
//  3 FIFO 1->2 full, we_1 and re_2 in same cycle -> pop of 0x01 occurs, new word dropped, ovf_1=1, level_2=3.
//  4 Both sides stream 10 words each concurrently with random re -> every word is received in order, including across the pointer wrap 3->0.
//  5 Two words buffered each way, assert resetn=0 mid-cycle -> all outputs 0 immediately, without waiting for clk.
//  6 NF_MAILBOX_IRQ_EN, irq_level=2: write 2 words from side 2 -> irq_1=1 one cycle after level_1=2.
//    Read 1 -> irq_1=0 one cycle later.

Source files
------------

// File: rtl/nf_mailbox.sv
// rtl/nf_mailbox.sv - bidirectional two-master mailbox built from two independent FIFOs
//
// Purpose: side 1 and side 2 exchange words through two depth-entry FIFOs
//   (1->2 written by side 1 / read by side 2, and 2->1 the mirror), with
//   flow control, fill levels and sticky overflow flags.
// Optional feature macro: NF_MAILBOX_IRQ_EN adds registered fill-level
//   interrupts irq_1 / irq_2 (asserted while level_x >= irq_level).
// Ports (x = 1 or 2, y = the other side):
//   clk, resetn            clock, asynchronous active-low reset
//   we_x, data_x_in        side x pushes a word into FIFO x->y
//   re_x                   side x pops the head of FIFO y->x
//   data_x_out, valid_x    head of FIFO y->x (fall-through) and its not-empty flag
//   wait_x                 FIFO x->y full; writes from side x are dropped
//   level_x                entries in FIFO y->x
//   ovf_x, ovf_clr_x       sticky dropped-write flag for side x and its clear
//   irq_x                  fill-level interrupt for FIFO y->x (NF_MAILBOX_IRQ_EN only)

module nf_mailbox_fifo #(
  parameter int width     = 8,
  parameter int depth     = 4,
  parameter int irq_level = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     we,
  input  logic [width-1:0]         wdata,
  input  logic                     re,
  input  logic                     ovf_clr,
  output logic [width-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(depth):0]   level,
  output logic                     ovf
`ifdef NF_MAILBOX_IRQ_EN
  ,
  output logic                     irq
`endif
);
  localparam int AW = $clog2(depth);
  localparam int LW = AW + 1;

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_wr, do_rd;

  // Accept/reject uses only the pre-edge count, so a pop in the same cycle
  // never makes room for a write into a full FIFO (and vice versa for empty).
  assign full  = (count_q == LW'(depth));
  assign valid = (count_q != '0);
  assign do_wr = we & ~full;
  assign do_rd = re & valid;
  assign rdata = mem_q[rd_ptr_q];
  assign level = count_q;
  assign ovf   = ovf_q;

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)     ovf_d = 1'b0;
    if (we && full)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef NF_MAILBOX_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq_q <= 1'b0;
    else         irq_q <= (count_q >= LW'(irq_level));
  end
  assign irq = irq_q;
`else
  // irq_level has no function without the interrupt feature.
  logic unused_irq_level;
  assign unused_irq_level = (irq_level != 0);
`endif
endmodule

module nf_mailbox #(
  parameter int width     = 8,
  parameter int depth     = 4,
  parameter int irq_level = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     we_1,
  input  logic [width-1:0]         data_1_in,
  input  logic                     re_1,
  output logic [width-1:0]         data_1_out,
  output logic                     valid_1,
  output logic                     wait_1,
  output logic [$clog2(depth):0]   level_1,
  output logic                     ovf_1,
  input  logic                     ovf_clr_1,
  input  logic                     we_2,
  input  logic [width-1:0]         data_2_in,
  input  logic                     re_2,
  output logic [width-1:0]         data_2_out,
  output logic                     valid_2,
  output logic                     wait_2,
  output logic [$clog2(depth):0]   level_2,
  output logic                     ovf_2,
  input  logic                     ovf_clr_2
`ifdef NF_MAILBOX_IRQ_EN
  ,
  output logic                     irq_1,
  output logic                     irq_2
`endif
);
  // FIFO 1->2: written by side 1, drained by side 2.
  nf_mailbox_fifo #(.width(width), .depth(depth), .irq_level(irq_level)) u_fifo_12 (
    .clk     (clk),
    .resetn  (resetn),
    .we      (we_1),
    .wdata   (data_1_in),
    .re      (re_2),
    .ovf_clr (ovf_clr_1),
    .rdata   (data_2_out),
    .valid   (valid_2),
    .full    (wait_1),
    .level   (level_2),
    .ovf     (ovf_1)
`ifdef NF_MAILBOX_IRQ_EN
    ,
    .irq     (irq_2)
`endif
  );

  // FIFO 2->1: written by side 2, drained by side 1.
  nf_mailbox_fifo #(.width(width), .depth(depth), .irq_level(irq_level)) u_fifo_21 (
    .clk     (clk),
    .resetn  (resetn),
    .we      (we_2),
    .wdata   (data_2_in),
    .re      (re_1),
    .ovf_clr (ovf_clr_2),
    .rdata   (data_1_out),
    .valid   (valid_1),
    .full    (wait_2),
    .level   (level_1),
    .ovf     (ovf_2)
`ifdef NF_MAILBOX_IRQ_EN
    ,
    .irq     (irq_1)
`endif
  );
endmodule

// File: tb/tb_nf_mailbox.sv
// tb/tb_nf_mailbox.sv - directed self-checking bench for nf_mailbox (width=8, depth=4)

module tb_nf_mailbox;
  logic       clk = 1'b0;
  logic       resetn;
  logic       we_1, re_1, ovf_clr_1, we_2, re_2, ovf_clr_2;
  logic [7:0] data_1_in, data_2_in, data_1_out, data_2_out;
  logic       valid_1, valid_2, wait_1, wait_2, ovf_1, ovf_2;
  logic [2:0] level_1, level_2;
`ifdef NF_MAILBOX_IRQ_EN
  logic       irq_1, irq_2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nf_mailbox #(.width(8), .depth(4), .irq_level(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .we_1       (we_1),
    .data_1_in  (data_1_in),
    .re_1       (re_1),
    .data_1_out (data_1_out),
    .valid_1    (valid_1),
    .wait_1     (wait_1),
    .level_1    (level_1),
    .ovf_1      (ovf_1),
    .ovf_clr_1  (ovf_clr_1),
    .we_2       (we_2),
    .data_2_in  (data_2_in),
    .re_2       (re_2),
    .data_2_out (data_2_out),
    .valid_2    (valid_2),
    .wait_2     (wait_2),
    .level_2    (level_2),
    .ovf_2      (ovf_2),
    .ovf_clr_2  (ovf_clr_2)
`ifdef NF_MAILBOX_IRQ_EN
    ,
    .irq_1      (irq_1),
    .irq_2      (irq_2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid_1"}, 32'(valid_1), 0);
    chk({tag, "_valid_2"}, 32'(valid_2), 0);
    chk({tag, "_wait_1"},  32'(wait_1), 0);
    chk({tag, "_wait_2"},  32'(wait_2), 0);
    chk({tag, "_level_1"}, 32'(level_1), 0);
    chk({tag, "_level_2"}, 32'(level_2), 0);
    chk({tag, "_ovf_1"},   32'(ovf_1), 0);
    chk({tag, "_ovf_2"},   32'(ovf_2), 0);
    chk({tag, "_dout_1"},  32'(data_1_out), 0);
    chk({tag, "_dout_2"},  32'(data_2_out), 0);
`ifdef NF_MAILBOX_IRQ_EN
    chk({tag, "_irq_1"},   32'(irq_1), 0);
    chk({tag, "_irq_2"},   32'(irq_2), 0);
`endif
  endtask

  initial begin
    int s1, s2, r1, r2;
    resetn = 1'b0;
    we_1 = 0; re_1 = 0; ovf_clr_1 = 0; data_1_in = '0;
    we_2 = 0; re_2 = 0; ovf_clr_2 = 0; data_2_in = '0;
    step();
    step();
    chk_all_zero("reset");
    resetn = 1'b1;

    // 1: single word 1->2
    we_1 = 1; data_1_in = 8'hA5;
    step();
    we_1 = 0;
    chk("t1_valid", 32'(valid_2), 1);
    chk("t1_data",  32'(data_2_out), 32'hA5);
    chk("t1_level", 32'(level_2), 1);
    re_2 = 1;
    step();
    re_2 = 0;
    chk("t1_valid_after_read", 32'(valid_2), 0);
    chk("t1_level_after_read", 32'(level_2), 0);

    // 2: fill, overflow, ordered drain, clear
    for (int i = 1; i <= 4; i++) begin
      we_1 = 1; data_1_in = 8'(i);
      step();
    end
    chk("t2_wait_full", 32'(wait_1), 1);
    chk("t2_level_full", 32'(level_2), 4);
    data_1_in = 8'h05;
    step();
    we_1 = 0;
    chk("t2_ovf_set", 32'(ovf_1), 1);
    chk("t2_level_after_drop", 32'(level_2), 4);
    chk("t2_ovf_2_quiet", 32'(ovf_2), 0);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain_data", 32'(data_2_out), 32'(i));
      re_2 = 1;
      step();
    end
    re_2 = 0;
    chk("t2_empty", 32'(valid_2), 0);
    chk("t2_ovf_sticky", 32'(ovf_1), 1);
    ovf_clr_1 = 1;
    step();
    ovf_clr_1 = 0;
    chk("t2_ovf_cleared", 32'(ovf_1), 0);

    // 3: full FIFO, write+read+clear in one cycle
    for (int i = 1; i <= 4; i++) begin
      we_1 = 1; data_1_in = 8'(i);
      step();
    end
    chk("t3_head", 32'(data_2_out), 32'h01);
    we_1 = 1; data_1_in = 8'h55; re_2 = 1; ovf_clr_1 = 1;
    step();
    we_1 = 0; re_2 = 0; ovf_clr_1 = 0;
    chk("t3_level", 32'(level_2), 3);
    chk("t3_ovf_set_wins", 32'(ovf_1), 1);
    chk("t3_wait_released", 32'(wait_1), 0);
    for (int i = 2; i <= 4; i++) begin
      chk("t3_drain_data", 32'(data_2_out), 32'(i));
      re_2 = 1;
      step();
    end
    re_2 = 0;
    chk("t3_empty", 32'(level_2), 0);
    ovf_clr_1 = 1;
    step();
    ovf_clr_1 = 0;

    // read while empty with a write landing in the same cycle
    re_2 = 1; we_1 = 1; data_1_in = 8'h77;
    step();
    we_1 = 0; re_2 = 0;
    chk("empty_rw_level", 32'(level_2), 1);
    chk("empty_rw_data", 32'(data_2_out), 32'h77);
    re_2 = 1;
    step();
    re_2 = 0;
    chk("empty_rw_drained", 32'(level_2), 0);

    // 4: concurrent streaming in both directions with random reads
    s1 = 0; s2 = 0; r1 = 0; r2 = 0;
    for (int cyc = 0; cyc < 400 && (r1 < 10 || r2 < 10); cyc++) begin
      we_1 = (s1 < 10) && !wait_1; data_1_in = 8'(16 + s1);
      we_2 = (s2 < 10) && !wait_2; data_2_in = 8'(128 + s2);
      re_2 = valid_2 && ($urandom_range(0, 1) == 1);
      re_1 = valid_1 && ($urandom_range(0, 1) == 1);
      if (re_2) begin
        chk("t4_data_12", 32'(data_2_out), 32'(16 + r2));
        r2++;
      end
      if (re_1) begin
        chk("t4_data_21", 32'(data_1_out), 32'(128 + r1));
        r1++;
      end
      step();
      if (we_1) s1++;
      if (we_2) s2++;
    end
    we_1 = 0; we_2 = 0; re_1 = 0; re_2 = 0;
    chk("t4_rcv_12", 32'(r2), 10);
    chk("t4_rcv_21", 32'(r1), 10);
    chk("t4_ovf_1", 32'(ovf_1), 0);
    chk("t4_ovf_2", 32'(ovf_2), 0);
    chk("t4_level_1", 32'(level_1), 0);
    chk("t4_level_2", 32'(level_2), 0);

    // 5: asynchronous reset with words buffered both ways
    for (int i = 0; i < 2; i++) begin
      we_1 = 1; data_1_in = 8'(8'hC0 + i);
      we_2 = 1; data_2_in = 8'(8'hD0 + i);
      step();
    end
    we_1 = 0; we_2 = 0;
    chk("t5_level_1", 32'(level_1), 2);
    chk("t5_level_2", 32'(level_2), 2);
    chk("t5_dout_1", 32'(data_1_out), 32'hD0);
    #2 resetn = 1'b0;
    #1 chk_all_zero("t5_async");
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk_all_zero("t5_after");

`ifdef NF_MAILBOX_IRQ_EN
    // 6: interrupt on level_1 >= 2
    we_2 = 1; data_2_in = 8'h31;
    step();
    data_2_in = 8'h32;
    step();
    we_2 = 0;
    chk("t6_level", 32'(level_1), 2);
    chk("t6_irq_not_yet", 32'(irq_1), 0);
    step();
    chk("t6_irq_set", 32'(irq_1), 1);
    chk("t6_irq_2_quiet", 32'(irq_2), 0);
    re_1 = 1;
    step();
    re_1 = 0;
    chk("t6_level_after_read", 32'(level_1), 1);
    chk("t6_irq_still", 32'(irq_1), 1);
    step();
    chk("t6_irq_cleared", 32'(irq_1), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
